// File: rtl/rename_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rename_ctrl_pkg
// Description : Shared CPU rename constants, tag/register types and the
//               rename controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rename_ctrl_pkg;

    // ROB tag width; tag 0 means "no producer, value lives in the RF"
    localparam int c_ROBBW    = 4;
    // Architectural register index width
    localparam int c_REGBW    = 5;
    // Usable tags are 1..c_CAP
    localparam int c_CAP      = (1 << c_ROBBW) - 1;
    // Register-file geometry
    localparam int c_RF_DEPTH = 1 << c_REGBW;

    typedef logic [c_ROBBW-1:0] tag_t;
    typedef logic [c_REGBW-1:0] reg_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage : rename_ctrl_pkg
`default_nettype wire

// File: rtl/rename_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rename_ctrl_if
// Description : Decode / register-file / ROB signal bundle around the rename
//               controller. slave = controller side, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface rename_ctrl_if
    import rename_ctrl_pkg::*;
#(
    parameter int ROBBW = c_ROBBW,
    parameter int REGBW = c_REGBW
);

    // decode side
    logic             dec_valid;
    logic             dec_ready;
    logic             dec_has_rd;
    logic [REGBW-1:0] dec_rd;
    logic [REGBW-1:0] dec_rs1;
    logic [REGBW-1:0] dec_rs2;

    // register-file side
    logic [REGBW-1:0] rf_rs1;
    logic [REGBW-1:0] rf_rs2;
    logic             rf_rn_valid;
    logic [REGBW-1:0] rf_rn_rd;
    logic [ROBBW-1:0] rf_rn_id;
    logic             rf_clear;

    // ROB / reservation-station side
    logic             alloc_valid;
    logic [ROBBW-1:0] alloc_id;
    logic             commit_valid;
    logic [ROBBW-1:0] commit_id;
    logic             flush;

    // status
    logic [ROBBW-1:0] count;
    logic             full;
    logic             err;

    modport slave (
        input  dec_valid, dec_has_rd, dec_rd, dec_rs1, dec_rs2,
        input  commit_valid, commit_id, flush,
        output dec_ready, rf_rs1, rf_rs2, rf_rn_valid, rf_rn_rd, rf_rn_id,
        output rf_clear, alloc_valid, alloc_id, count, full, err
    );

    modport master (
        output dec_valid, dec_has_rd, dec_rd, dec_rs1, dec_rs2,
        output commit_valid, commit_id, flush,
        input  dec_ready, rf_rs1, rf_rs2, rf_rn_valid, rf_rn_rd, rf_rn_id,
        input  rf_clear, alloc_valid, alloc_id, count, full, err
    );

endinterface : rename_ctrl_if
`default_nettype wire

// File: rtl/rename_ctrl_tag_ring.sv
`default_nettype none
// ============================================================================
// Module      : tag_ring
// Description : Wrapping tag counter over 1..(2^W-1); never holds 0.
//               Enable advances, synchronous clear returns to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_ring
    import rename_ctrl_pkg::*;
#(
    parameter int W = c_ROBBW
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         en,
    input  wire logic         clr,
    output logic      [W-1:0] tag
);

    localparam logic [W-1:0] c_LAST  = '1;
    localparam logic [W-1:0] c_FIRST = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_tag;

    // Advance through 1..LAST, wrapping past 0; clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= c_FIRST;
        end else if (clr) begin
            r_tag <= c_FIRST;
        end else if (en) begin
            r_tag <= (r_tag == c_LAST) ? c_FIRST : r_tag + 1'b1;
        end
    end

    assign tag = r_tag;

endmodule : tag_ring
`default_nettype wire

// File: rtl/rename_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rename_ctrl
// Description : Register-rename / ROB tag allocator. Hands out tags in order
//               at decode, frees them in order at commit, and wipes all
//               rename state on a mispredict flush.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_ctrl
    import rename_ctrl_pkg::*;
#(
    parameter int ROBBW = c_ROBBW,
    parameter int REGBW = c_REGBW
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   rdy,
    rename_ctrl_if.slave bus
);

    localparam logic [ROBBW-1:0] c_CAP_TAG = '1;
    localparam logic [ROBBW-1:0] c_ZERO    = '0;
    localparam logic [REGBW-1:0] c_REG0    = '0;

    state_t           r_state;
    logic             r_rf_clear;
    logic [ROBBW-1:0] r_count;
    logic             r_err;

    logic [ROBBW-1:0] w_head;
    logic [ROBBW-1:0] w_tail;
    logic             w_full;
    logic             w_ready;
    logic             w_accept;
    logic             w_flush_go;
    logic             w_commit_req;
    logic             w_commit_bad;
    logic             w_commit_ok;

    // Flush wins over everything that happens in the same cycle.
    assign w_flush_go   = bus.flush && rdy;
    assign w_full       = (r_count == c_CAP_TAG);
    // rst_n gates ready so nothing looks acceptable while reset is held.
    assign w_ready      = rst_n && rdy && (r_state == ST_RUN) && !w_full && !bus.flush;
    assign w_accept     = bus.dec_valid && w_ready;
    assign w_commit_req = bus.commit_valid && rdy && !bus.flush;
    // Out-of-order or underflowing commits are dropped and flagged.
    assign w_commit_bad = w_commit_req && ((r_count == c_ZERO) || (bus.commit_id != w_head));
    assign w_commit_ok  = w_commit_req && !w_commit_bad;

    tag_ring #(.W(ROBBW)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_accept),
        .clr   (w_flush_go),
        .tag   (w_tail)
    );

    tag_ring #(.W(ROBBW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_commit_ok),
        .clr   (w_flush_go),
        .tag   (w_head)
    );

    // Run/flush sequencer; rf_clear is the registered image of the FLUSH state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_rf_clear <= 1'b0;
        end else if (rdy) begin
            case (r_state)
                ST_RUN: begin
                    if (bus.flush) begin
                        r_state    <= ST_FLUSH;
                        r_rf_clear <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (bus.flush) begin
                        r_state    <= ST_FLUSH;
                        r_rf_clear <= 1'b1;
                    end else begin
                        r_state    <= ST_RUN;
                        r_rf_clear <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_rf_clear <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy: +1 per accept, -1 per good commit, both together cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= c_ZERO;
        end else if (w_flush_go) begin
            r_count <= c_ZERO;
        end else if (w_accept && !w_commit_ok) begin
            r_count <= r_count + 1'b1;
        end else if (!w_accept && w_commit_ok) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Sticky protocol-error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_commit_bad) begin
            r_err <= 1'b1;
        end
    end

    assign bus.rf_rs1      = bus.dec_rs1;
    assign bus.rf_rs2      = bus.dec_rs2;
    assign bus.dec_ready   = w_ready;
    assign bus.alloc_valid = w_accept;
    assign bus.alloc_id    = w_tail;
    assign bus.rf_rn_valid = w_accept && bus.dec_has_rd && (bus.dec_rd != c_REG0);
    assign bus.rf_rn_rd    = bus.dec_rd;
    assign bus.rf_rn_id    = w_tail;
    assign bus.rf_clear    = r_rf_clear && rdy;
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.err         = r_err;

endmodule : rename_ctrl
`default_nettype wire

// File: tb/tb_rename_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_ctrl
// Description : Directed self-checking bench for rename_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_ctrl;

    logic clk;
    logic rst_n;
    logic rdy;

    int n_total;
    int n_bad;

    rename_ctrl_if #(.ROBBW(4), .REGBW(5)) bus ();

    rename_ctrl #(.ROBBW(4), .REGBW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted decode; checks the same-cycle allocation outputs.
    task automatic accept(input logic has_rd, input logic [4:0] rd,
                          input logic [3:0] id, input logic rn);
        bus.dec_valid  = 1'b1;
        bus.dec_has_rd = has_rd;
        bus.dec_rd     = rd;
        #1;
        chk("alloc_valid", 32'(bus.alloc_valid), 32'd1);
        chk("alloc_id",    32'(bus.alloc_id),    32'(id));
        chk("rn_valid",    32'(bus.rf_rn_valid), 32'(rn));
        chk("rn_id",       32'(bus.rf_rn_id),    32'(id));
        step();
        bus.dec_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] id);
        bus.commit_valid = 1'b1;
        bus.commit_id    = id;
        step();
        bus.commit_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        rdy     = 1'b1;
        bus.dec_valid    = 1'b1;
        bus.dec_has_rd   = 1'b1;
        bus.dec_rd       = 5'd1;
        bus.dec_rs1      = 5'd3;
        bus.dec_rs2      = 5'd9;
        bus.commit_valid = 1'b0;
        bus.commit_id    = 4'd0;
        bus.flush        = 1'b0;
        #2;
        // reset state
        chk("rst_count",   32'(bus.count),       32'd0);
        chk("rst_full",    32'(bus.full),        32'd0);
        chk("rst_err",     32'(bus.err),         32'd0);
        chk("rst_ready",   32'(bus.dec_ready),   32'd0);
        chk("rst_alloc",   32'(bus.alloc_valid), 32'd0);
        chk("rst_rn",      32'(bus.rf_rn_valid), 32'd0);
        chk("rst_clear",   32'(bus.rf_clear),    32'd0);
        chk("rf_rs1",      32'(bus.rf_rs1),      32'd3);
        chk("rf_rs2",      32'(bus.rf_rs2),      32'd9);
        step();
        step();
        bus.dec_valid = 1'b0;
        rst_n = 1'b1;

        // three accepts right after reset: rd=5, rd=0, rd=7
        accept(1'b1, 5'd5, 4'd1, 1'b1);
        accept(1'b1, 5'd0, 4'd2, 1'b0);
        accept(1'b1, 5'd7, 4'd3, 1'b1);
        chk("count_3", 32'(bus.count), 32'd3);

        // rdy low for three cycles with decode and commit pending
        rdy = 1'b0;
        bus.dec_valid    = 1'b1;
        bus.commit_valid = 1'b1;
        bus.commit_id    = 4'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_alloc", 32'(bus.alloc_valid), 32'd0);
            chk("stall_ready", 32'(bus.dec_ready),   32'd0);
            step();
        end
        bus.dec_valid    = 1'b0;
        bus.commit_valid = 1'b0;
        rdy = 1'b1;
        chk("stall_count", 32'(bus.count), 32'd3);
        chk("stall_err",   32'(bus.err),   32'd0);
        accept(1'b1, 5'd1, 4'd4, 1'b1);
        chk("count_4", 32'(bus.count), 32'd4);

        // simultaneous accept and commit at count 4
        bus.dec_valid    = 1'b1;
        bus.dec_rd       = 5'd2;
        bus.commit_valid = 1'b1;
        bus.commit_id    = 4'd1;
        #1;
        chk("sim_alloc_id", 32'(bus.alloc_id), 32'd5);
        step();
        bus.dec_valid    = 1'b0;
        bus.commit_valid = 1'b0;
        chk("sim_count", 32'(bus.count), 32'd4);
        commit(4'd2);
        chk("head_adv_err", 32'(bus.err),   32'd0);
        chk("head_adv_cnt", 32'(bus.count), 32'd3);
        accept(1'b1, 5'd3, 4'd6, 1'b1);
        accept(1'b1, 5'd4, 4'd7, 1'b1);
        accept(1'b1, 5'd6, 4'd8, 1'b1);
        chk("count_6", 32'(bus.count), 32'd6);

        // flush with decode and commit also requested
        bus.dec_valid    = 1'b1;
        bus.commit_valid = 1'b1;
        bus.commit_id    = 4'd3;
        bus.flush        = 1'b1;
        #1;
        chk("fl_alloc", 32'(bus.alloc_valid), 32'd0);
        chk("fl_ready", 32'(bus.dec_ready),   32'd0);
        chk("fl_clr0",  32'(bus.rf_clear),    32'd0);
        step();
        bus.flush        = 1'b0;
        bus.dec_valid    = 1'b0;
        bus.commit_valid = 1'b0;
        chk("fl_clr1",  32'(bus.rf_clear),  32'd1);
        chk("fl_count", 32'(bus.count),     32'd0);
        chk("fl_ready1", 32'(bus.dec_ready), 32'd0);
        step();
        chk("fl_clr2",  32'(bus.rf_clear),  32'd0);
        chk("fl_ready2", 32'(bus.dec_ready), 32'd1);
        chk("fl_err",   32'(bus.err),       32'd0);

        // fill all 15 tags starting from 1
        for (int i = 1; i <= 15; i++) begin
            accept(1'b1, 5'(i), 4'(i), 1'b1);
        end
        chk("full_count", 32'(bus.count), 32'd15);
        chk("full_flag",  32'(bus.full),  32'd1);
        bus.dec_valid = 1'b1;
        #1;
        chk("full_ready", 32'(bus.dec_ready),   32'd0);
        chk("full_alloc", 32'(bus.alloc_valid), 32'd0);
        step();
        bus.dec_valid = 1'b0;
        chk("full_hold", 32'(bus.count), 32'd15);
        commit(4'd1);
        chk("free_count", 32'(bus.count),     32'd14);
        chk("free_full",  32'(bus.full),      32'd0);
        chk("free_ready", 32'(bus.dec_ready), 32'd1);
        accept(1'b1, 5'd9, 4'd1, 1'b1);

        // out-of-order commit: id 3 while head is 2
        commit(4'd3);
        chk("ooo_err",   32'(bus.err),   32'd1);
        chk("ooo_count", 32'(bus.count), 32'd15);
        commit(4'd2);
        chk("ooo_head",  32'(bus.count), 32'd14);
        chk("ooo_stick", 32'(bus.err),   32'd1);

        // flush held two cycles, then reset while still in FLUSH
        bus.flush = 1'b1;
        step();
        chk("ext_clr1", 32'(bus.rf_clear), 32'd1);
        step();
        bus.flush = 1'b0;
        #1;
        chk("ext_clr2",  32'(bus.rf_clear),  32'd1);
        chk("ext_ready", 32'(bus.dec_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstfl_clr",   32'(bus.rf_clear),  32'd0);
        chk("rstfl_count", 32'(bus.count),     32'd0);
        chk("rstfl_err",   32'(bus.err),       32'd0);
        chk("rstfl_ready", 32'(bus.dec_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_clr", 32'(bus.rf_clear), 32'd0);

        // commit with nothing outstanding
        commit(4'd1);
        chk("uf_err",   32'(bus.err),   32'd1);
        chk("uf_count", 32'(bus.count), 32'd0);
        accept(1'b1, 5'd5, 4'd1, 1'b1);
        commit(4'd1);
        chk("uf_count2", 32'(bus.count), 32'd0);
        chk("uf_stick",  32'(bus.err),   32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_rename_ctrl
`default_nettype wire

// File: doc/rename_ctrl.md
RENAME_CTRL -- requirements
Module: rename_ctrl

Interface
REQ-001 SHALL have parameter ROBBW, default 4, meaning ROB tag width; tag 0 is reserved for "no producer / value in register file".
REQ-002 SHALL have parameter REGBW, default 5, meaning architectural register index width.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port rdy  in  1  global enable; when low, all state is held and no handshake completes.
REQ-005 SHALL have decode side ports: dec_valid in 1; dec_ready out 1; dec_has_rd in 1; dec_rd in REGBW; dec_rs1 in REGBW; dec_rs2 in REGBW.
REQ-006 SHALL have register-file ports: rf_rs1 out REGBW; rf_rs2 out REGBW; rf_rn_valid out 1; rf_rn_rd out REGBW; rf_rn_id out ROBBW; rf_clear out 1 (clears every rename tag).
REQ-007 SHALL have ROB/RS ports: alloc_valid out 1; alloc_id out ROBBW; commit_valid in 1; commit_id in ROBBW; flush in 1 (mispredict).
REQ-008 SHALL have status ports: count out ROBBW (occupancy); full out 1; err out 1 (sticky protocol error).

Function
REQ-009 SHALL hold capacity CAP = 2^ROBBW - 1 (15 at default), tags 1..CAP in use.
REQ-010 SHALL keep tail (next tag to allocate) and head (oldest outstanding tag), each wrapping CAP -> 1 and never taking the value 0.
REQ-011 SHALL drive rf_rs1/rf_rs2 combinationally from dec_rs1/dec_rs2 in every cycle.
REQ-012 SHALL assert dec_ready = rdy && state==RUN && !full && !flush.
REQ-013 SHALL accept an instruction on dec_valid && dec_ready; in that same cycle alloc_valid=1 and alloc_id=tail; tail advances at the clock edge.
REQ-014 SHALL assert rf_rn_valid in the accept cycle only when dec_has_rd=1 and dec_rd!=0, with rf_rn_rd=dec_rd and rf_rn_id=tail; otherwise rf_rn_valid=0 and the tag is still allocated.
REQ-015 SHALL free one tag per cycle on commit_valid && rdy: head advances and count decrements.
REQ-016 SHALL keep count unchanged on a simultaneous accept and commit; full = (count==CAP).
REQ-017 SHALL set err when commit_valid arrives with count==0 or with commit_id!=head; the offending commit is ignored, and err is cleared only by reset.
REQ-018 SHALL implement state machine RUN -> FLUSH on flush && rdy; in FLUSH, drive rf_clear=1 for exactly one cycle, hold dec_ready=0, then return to RUN.
REQ-019 SHALL give flush priority over same-cycle accept and commit: neither takes effect, and on entry to FLUSH head=tail=1 and count=0.
REQ-020 SHALL treat flush asserted while in FLUSH as extending FLUSH by one more cycle.
REQ-021 SHALL, when rdy=0, drive alloc_valid=0, rf_rn_valid=0 and rf_clear=0, and hold all registers.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force: state=RUN, head=1, tail=1, count=0, err=0, full=0, rf_clear=0, alloc_valid=0, rf_rn_valid=0, dec_ready=0.
REQ-023 SHALL, when reset asserts mid-FLUSH or mid-accept, discard the operation with no residual rf_clear or rename pulse after release.
REQ-024 SHALL allow the first accept on the first rising edge after rst_n deasserts with rdy=1.

Structure
REQ-025 SHALL take ROBBW, REGBW, CAP and the tag and register-index types from the shared CPU package, alongside the register-file widths.
REQ-026 SHALL instantiate two copies of one sub-module, tag_ring, a 1..CAP wrapping counter with enable and synchronous clear, for head and tail.

Verification
REQ-027 SHALL cover: after reset, 3 accepts with rd=5,0,7 -> alloc_id 1,2,3; rf_rn_valid 1,0,1; count=3.
REQ-028 SHALL cover: 15 accepts with no commit -> full=1, dec_ready=0, 16th request stalls; then one commit (id=1) -> dec_ready=1 and next alloc_id=1 (wrap skips 0).
REQ-029 SHALL cover: count=4 with accept and commit in the same cycle -> count stays 4, tail and head each +1.
REQ-030 SHALL cover: flush with dec_valid and commit_valid high at count=6 -> no alloc, rf_clear high for one cycle, count=0, next alloc_id=1.
REQ-031 SHALL cover: commit_valid at count=0, and commit_id=3 when head=2 -> err=1 and stays set; count and head unchanged.
REQ-032 SHALL cover: rdy=0 for 3 cycles during dec_valid -> no alloc_valid and state frozen; rst_n low during FLUSH -> rf_clear=0 immediately and count=0.
